// File: rtl/loop_ctrl_pkg.sv
// Shared types for the clockless loop entry/exit steering block.
// State encoding is fixed so that the unused code (2'b11) can be recognised and recovered.
package loop_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOOP = 2'b01,
    EXIT = 2'b10,
    ILL  = 2'b11
  } state_t;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/async_dcnt.sv
// Down-counter stepped on the falling edge of ev, with async clear and synchronous-to-ev load.
// Holds at zero rather than wrapping; zero is flagged combinationally.
module async_dcnt
  import loop_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clr,
  input  logic         ev,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clr or negedge ev) begin
    if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (!zero) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/loop_ctrl.sv
// Clockless loop entry/exit steering: req1 enters, req2 loops back iterN-1 times, then exits on done.
// Optional macro LOOP_CTRL_IDX_EN adds the idx output (completed body passes).
module loop_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             rstReq,
  output logic             rstFin,
  input  logic             req1,
  input  logic [CNT_W-1:0] iterN,
  input  logic             req2,
  output logic             fin,
  output logic             done
`ifdef LOOP_CTRL_IDX_EN
  ,
  output logic [CNT_W-1:0] idx
`endif
);

  state_t           st;
  state_t           st_nxt;
  logic             blk;
  logic             arm;
  logic             r1;
  logic             step;
  logic             ld;
  logic             cnt_zero;
  logic             iter_zero;
  logic [CNT_W-1:0] ld_val;

  // blk masks a req1 that is still high when reset releases; it clears once
  // reset and req1 are both low, i.e. on the falling edge of arm.
  assign arm = rstReq | req1;
  assign r1  = req1 & ~blk;

  always_ff @(posedge rstReq or negedge arm) begin
    if (rstReq) begin
      blk <= 1'b1;
    end else begin
      blk <= 1'b0;
    end
  end

  assign iter_zero = (iterN == '0);
  assign ld_val    = (iterN <= CNT_W'(1)) ? '0 : iterN - CNT_W'(2);
  assign rstFin    = (st == IDLE);

  // step is the one request the current state follows; its falling edge advances the FSM.
  always_ff @(posedge rstReq or negedge step) begin
    if (rstReq) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    step   = 1'b0;
    fin    = 1'b0;
    done   = 1'b0;
    ld     = 1'b0;
    case (st)
      IDLE: begin
        step = r1;
        ld   = 1'b1;
        fin  = r1 & ~iter_zero;
        done = r1 & iter_zero;
        if (iter_zero) begin
          st_nxt = IDLE;
        end else if (iterN == CNT_W'(1)) begin
          st_nxt = EXIT;
        end else begin
          st_nxt = LOOP;
        end
      end
      LOOP: begin
        step   = req2;
        fin    = req2;
        st_nxt = cnt_zero ? EXIT : LOOP;
      end
      EXIT: begin
        step   = req2;
        done   = req2;
        st_nxt = IDLE;
      end
      default: begin
        step   = req1 | req2;
        st_nxt = IDLE;
      end
    endcase
    if (rstReq) begin
      fin  = 1'b0;
      done = 1'b0;
    end
  end

  async_dcnt #(.W(CNT_W)) u_cnt (
    .clr    (rstReq),
    .ev     (step),
    .ld     (ld),
    .ld_val (ld_val),
    .zero   (cnt_zero)
  );

`ifdef LOOP_CTRL_IDX_EN
  always_ff @(posedge rstReq or negedge step) begin
    if (rstReq) begin
      idx <= '0;
    end else if (st == IDLE && !iter_zero) begin
      idx <= CNT_W'(1);
    end else if (st == LOOP) begin
      idx <= idx + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_loop_ctrl.sv
// Scoreboard bench for loop_ctrl: a token-level model queues the expected fin/done pulses,
// and a monitor pops and compares on every observed rising output.
module tb_loop_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstReq = 1'b0;
  logic         req1 = 1'b0;
  logic         req2 = 1'b0;
  logic [W-1:0] iterN = '0;
  logic         rstFin;
  logic         fin;
  logic         done;
`ifdef LOOP_CTRL_IDX_EN
  logic [W-1:0] idx;
`endif

  always #5 clk = ~clk;

  loop_ctrl #(.CNT_W(W)) dut (
    .rstReq (rstReq),
    .rstFin (rstFin),
    .req1   (req1),
    .iterN  (iterN),
    .req2   (req2),
    .fin    (fin),
    .done   (done)
`ifdef LOOP_CTRL_IDX_EN
    ,
    .idx    (idx)
`endif
  );

  int total = 0;
  int bad = 0;

  // expected token kinds: 0 = fin pulse, 1 = done pulse
  int exp_q[$];

  // reference model: is a loop in progress, how many loop-back passes are still owed
  bit active = 1'b0;
  int owed = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic pf = 1'b0;
  logic pd = 1'b0;

  always @(posedge clk) begin
    int e;
    if (fin && !pf) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("token_fin", 0, e);
    end
    if (done && !pd) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("token_done", 1, e);
    end
    pf = fin;
    pd = done;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idx();
`ifdef LOOP_CTRL_IDX_EN
    chk("idx", int'(idx), passes);
`endif
  endtask

  task automatic entry(input int n);
    iterN = W'(n);
    wait_n(1);
    if (!active) begin
      if (n == 0) begin
        exp_q.push_back(1);
      end else begin
        exp_q.push_back(0);
        active = 1'b1;
        owed   = n - 1;
        passes = 1;
      end
    end
    req1 = 1'b1;
    wait_n(3);
    chk("rstFin_req1_high", int'(rstFin), 1);
    req1 = 1'b0;
    wait_n(3);
    chk("rstFin_after_req1", int'(rstFin), active ? 0 : 1);
    check_idx();
  endtask

  task automatic loopback();
    if (active) begin
      if (owed > 0) begin
        exp_q.push_back(0);
        owed--;
        passes++;
      end else begin
        exp_q.push_back(1);
        active = 1'b0;
      end
    end
    req2 = 1'b1;
    wait_n(3);
    req2 = 1'b0;
    wait_n(3);
    chk("rstFin_after_req2", int'(rstFin), active ? 0 : 1);
    check_idx();
  endtask

  task automatic drain();
    wait_n(2);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic reset_pulse();
    rstReq = 1'b1;
    active = 1'b0;
    owed   = 0;
    passes = 0;
    wait_n(2);
    chk("rst_rstFin", int'(rstFin), 1);
    rstReq = 1'b0;
    wait_n(2);
    check_idx();
  endtask

  initial begin
    #1 rstReq = 1'b1;
    req1 = 1'b1;
    wait_n(2);
    chk("rst_fin", int'(fin), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rstFin", int'(rstFin), 1);
    rstReq = 1'b0;
    wait_n(2);
    chk("released_req1_high_fin", int'(fin), 0);
    req1 = 1'b0;
    wait_n(2);
    chk("released_req1_low_fin", int'(fin), 0);
    chk("released_rstFin", int'(rstFin), 1);
    check_idx();

    // three iterations
    entry(3);
    repeat (3) loopback();
    drain();

    // single iteration, then zero-iteration bypass
    entry(1);
    loopback();
    drain();
    entry(0);
    drain();

    // reset mid-loop, stray loop-back, then a fresh entry
    entry(5);
    loopback();
    drain();
    reset_pulse();
    loopback();
    drain();
    entry(2);
    repeat (2) loopback();
    drain();

    // maximum count
    entry(15);
    repeat (15) loopback();
    drain();

    for (int k = 0; k < 25; k++) begin
      int n;
      n = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) loopback();
      entry(n);
      while (active) loopback();
      drain();
    end

    wait_n(4);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
